multicycle_controller: RTL and testbench

- Sequencing FSM for the multicycle build of the processor. It replaces per-instruction combinational control with a state machine that drives one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction.
- Owns the NZCV flags register and condition evaluation.
- Stalls on a memory-ready handshake.
- Stretches MUL over a fixed number of execute cycles.

---
 rtl/multicycle_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle sequencing controller: steps one shared ALU, a unified memory
// port and the register file through each instruction, owns the NZCV
// register and stretches MUL over MUL_CYCLES execute cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE   | read registers, evaluate condition, choose instruction path
// MEMADR   | ALU forms base + offset for LDR/STR
// MEMRD    | LDR read at ALUOut, waits for memory ready
// MEMWB    | LDR result into Rd (or PC when Rd = r15)
// MEMWR    | STR write strobe held until memory accepts it
// EXECR    | data-processing op, register operand B
// EXECI    | data-processing op, immediate operand B
// ALUWB    | data-processing result into Rd (or PC), skipped for CMP
// BRANCH   | PC <= PC+8+offset
module multicycle_controller #(
    parameter int MUL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] mul_cnt;

    logic [3:0] opc;
    logic       s_bit;
    logic       is_add;
    logic       is_sub;
    logic       is_cmp;
    logic       is_mul;
    logic       is_and;
    logic       is_orr;
    logic       op_defined;
    logic [2:0] alu_dec;
    logic       cond_ok;
    logic       in_exec;
    logic       exec_last;
    logic       rd_is_pc;

    logic       pcw_raw;
    logic       irw_raw;
    logic       rw_raw;
    logic       mw_raw;

    assign opc        = Funct[4:1];
    assign s_bit      = Funct[0];
    assign is_add     = (opc == 4'b0000);
    assign is_sub     = (opc == 4'b0010);
    assign is_cmp     = (opc == 4'b0100);
    assign is_mul     = (opc == 4'b0001);
    assign is_and     = (opc == 4'b1100);
    assign is_orr     = (opc == 4'b1110);
    assign op_defined = is_add | is_sub | is_cmp | is_mul | is_and | is_orr;
    assign rd_is_pc   = (Rd == 4'hF);
    assign in_exec    = (state == S_EXECR) || (state == S_EXECI);
    // The counter sits at zero on the last execute cycle of every op.
    assign exec_last  = (mul_cnt == 4'd0);

    // ALU operation selected by the data-processing opcode.
    always_comb begin
        alu_dec = 3'b000;
        if (is_sub || is_cmp) alu_dec = 3'b001;
        else if (is_mul)      alu_dec = 3'b010;
        else if (is_and)      alu_dec = 3'b100;
        else if (is_orr)      alu_dec = 3'b101;
    end

    // Condition field evaluated against the stored NZCV register.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = Flags;
        cond_ok = 1'b0;
        case (Cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = ~z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = ~c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = ~n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = ~v;
            4'b1000: cond_ok = c & ~z;
            4'b1001: cond_ok = ~c | z;
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = ~z & (n == v);
            4'b1101: cond_ok = z | (n != v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Extender and register-read selects follow the instruction class directly.
    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        case (Op)
            2'b01: begin ImmSrc = 2'b01; RegSrc = 2'b10; end
            2'b10: begin ImmSrc = 2'b10; RegSrc = 2'b01; end
            default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Execute-length down-counter, loaded in DECODE so it is ready on EXEC entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt <= 4'd0;
        end else if (state == S_DECODE) begin
            mul_cnt <= is_mul ? MUL_LOAD : 4'd0;
        end else if (in_exec && !exec_last) begin
            mul_cnt <= mul_cnt - 4'd1;
        end
    end

    // NZCV update on the final execute cycle; C,V only for arithmetic ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else if (in_exec && exec_last && (s_bit || is_cmp)) begin
            Flags[3:2] <= ALUFlags[3:2];
            if (is_add || is_sub || is_cmp) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Next-state and datapath controls for the current state.
    always_comb begin
        state_next = state;
        pcw_raw    = 1'b0;
        irw_raw    = 1'b0;
        rw_raw     = 1'b0;
        mw_raw     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    irw_raw    = 1'b1;
                    pcw_raw    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!cond_ok) begin
                    state_next = S_FETCH;
                end else begin
                    case (Op)
                        2'b00: begin
                            if (!op_defined)   state_next = S_FETCH;
                            else if (Funct[5]) state_next = S_EXECI;
                            else               state_next = S_EXECR;
                        end
                        2'b01:   state_next = S_MEMADR;
                        2'b10:   state_next = S_BRANCH;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                pcw_raw    = rd_is_pc;
                rw_raw     = ~rd_is_pc;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mw_raw = 1'b1;
                if (MemReady) state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                if (exec_last) state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = 2'b00;
                pcw_raw    = ~is_cmp & rd_is_pc;
                rw_raw     = ~is_cmp & ~rd_is_pc;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pcw_raw    = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Architectural write enables are suppressed in any cycle reset is high.
    assign PCWrite  = pcw_raw & ~reset;
    assign IRWrite  = irw_raw & ~reset;
    assign RegWrite = rw_raw  & ~reset;
    assign MemWrite = mw_raw  & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle's expected control
// word is queued when stimulus is applied and compared when sampled.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [2:0] aluc;
        logic [3:0] flags;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;

    logic [3:0] mflags;
    exp_t       exp_q[$];
    string      tag_q[$];
    int         n_cmp;
    int         n_fail;

    multicycle_controller #(.MUL_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .Flags(Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t base();
        exp_t e;
        e = '0;
        case (Op)
            2'b01:   begin e.imm = 2'b01; e.regsrc = 2'b10; end
            2'b10:   begin e.imm = 2'b10; e.regsrc = 2'b01; end
            default: begin e.imm = 2'b00; e.regsrc = 2'b00; end
        endcase
        e.flags = mflags;
        return e;
    endfunction

    function automatic exp_t ex_fetch(input bit go);
        exp_t e = base();
        e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
        e.pcw = go; e.irw = go;
        return e;
    endfunction

    function automatic exp_t ex_decode();
        exp_t e = base();
        e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
        return e;
    endfunction

    function automatic exp_t ex_memadr();
        exp_t e = base();
        e.srcb = 2'b01;
        return e;
    endfunction

    function automatic exp_t ex_memrd();
        exp_t e = base();
        e.adr = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_memwb(input bit rd15);
        exp_t e = base();
        e.res = 2'b01; e.pcw = rd15; e.rw = ~rd15;
        return e;
    endfunction

    function automatic exp_t ex_memwr();
        exp_t e = base();
        e.adr = 1'b1; e.mw = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_exec(input bit imm, input logic [2:0] aluc);
        exp_t e = base();
        e.srcb = imm ? 2'b01 : 2'b00; e.aluc = aluc;
        return e;
    endfunction

    function automatic exp_t ex_aluwb(input bit cmp, input bit rd15);
        exp_t e = base();
        e.res = 2'b00; e.pcw = ~cmp & rd15; e.rw = ~cmp & ~rd15;
        return e;
    endfunction

    function automatic exp_t ex_branch();
        exp_t e = base();
        e.srcb = 2'b01; e.res = 2'b10; e.pcw = 1'b1;
        return e;
    endfunction

    task automatic instr(input logic [3:0] c, input logic [1:0] o,
                         input logic [5:0] f, input logic [3:0] r);
        Cond = c; Op = o; Funct = f; Rd = r;
    endtask

    // One clock: queue the expectation, sample mid-low-phase, compare, advance.
    task automatic cyc(input string tag, input exp_t e_in);
        exp_t e;
        exp_t obs;
        string t;
        e = e_in;
        if (reset) begin
            e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, RegSrc, ALUControl, Flags};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", t, obs, e);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; mflags = 4'b0000;
        reset = 1'b1; MemReady = 1'b1; ALUFlags = 4'b0110;
        instr(4'hE, 2'b00, 6'b000001, 4'd1);
        @(negedge clk);
        cyc("reset_hold", ex_fetch(1));

        // ADDS interrupted by reset in EXECR
        reset = 1'b0;
        cyc("adds_a_fetch", ex_fetch(1));
        cyc("adds_a_decode", ex_decode());
        reset = 1'b1;
        cyc("adds_a_exec_rst", ex_exec(0, 3'b000));
        reset = 1'b0;
        cyc("post_rst_fetch", ex_fetch(1));
        cyc("adds_decode", ex_decode());
        cyc("adds_exec", ex_exec(0, 3'b000));
        mflags = 4'b0110;
        cyc("adds_aluwb", ex_aluwb(0, 0));

        // MUL without S: three execute cycles, flags untouched
        instr(4'hE, 2'b00, 6'b000010, 4'd2);
        ALUFlags = 4'b1111;
        cyc("mul_fetch", ex_fetch(1));
        cyc("mul_decode", ex_decode());
        cyc("mul_exec1", ex_exec(0, 3'b010));
        cyc("mul_exec2", ex_exec(0, 3'b010));
        cyc("mul_exec3", ex_exec(0, 3'b010));
        cyc("mul_aluwb", ex_aluwb(0, 0));

        // STR with a fetch stall and two write wait states
        instr(4'hE, 2'b01, 6'b011000, 4'd3);
        MemReady = 1'b0;
        cyc("str_fetch_stall", ex_fetch(0));
        MemReady = 1'b1;
        cyc("str_fetch", ex_fetch(1));
        cyc("str_decode", ex_decode());
        cyc("str_memadr", ex_memadr());
        MemReady = 1'b0;
        cyc("str_memwr1", ex_memwr());
        cyc("str_memwr2", ex_memwr());
        MemReady = 1'b1;
        cyc("str_memwr3", ex_memwr());

        // CMP register form loads all four flags, writes nothing
        instr(4'hE, 2'b00, 6'b001001, 4'd0);
        ALUFlags = 4'b1001;
        cyc("cmp_fetch", ex_fetch(1));
        cyc("cmp_decode", ex_decode());
        cyc("cmp_exec", ex_exec(0, 3'b001));
        mflags = 4'b1001;
        cyc("cmp_aluwb", ex_aluwb(1, 0));

        // CMP immediate form brings flags to 0100
        instr(4'hE, 2'b00, 6'b101001, 4'd0);
        ALUFlags = 4'b0100;
        cyc("cmpi_fetch", ex_fetch(1));
        cyc("cmpi_decode", ex_decode());
        cyc("cmpi_exec", ex_exec(1, 3'b001));
        mflags = 4'b0100;
        cyc("cmpi_aluwb", ex_aluwb(1, 0));

        // BNE fails with Z set, BEQ takes the branch
        instr(4'h1, 2'b10, 6'b100000, 4'd0);
        cyc("bne_fetch", ex_fetch(1));
        cyc("bne_decode", ex_decode());
        instr(4'h0, 2'b10, 6'b100000, 4'd0);
        cyc("beq_fetch", ex_fetch(1));
        cyc("beq_decode", ex_decode());
        cyc("beq_branch", ex_branch());

        // LDR into r15 with one read wait state
        instr(4'hE, 2'b01, 6'b011001, 4'd15);
        cyc("ldr_fetch", ex_fetch(1));
        cyc("ldr_decode", ex_decode());
        cyc("ldr_memadr", ex_memadr());
        MemReady = 1'b0;
        cyc("ldr_memrd_wait", ex_memrd());
        MemReady = 1'b1;
        cyc("ldr_memrd", ex_memrd());
        cyc("ldr_memwb", ex_memwb(1));

        // Never-condition and undefined opcode both act as NOPs
        instr(4'hF, 2'b00, 6'b000001, 4'd4);
        cyc("nv_fetch", ex_fetch(1));
        cyc("nv_decode", ex_decode());
        instr(4'hE, 2'b00, 6'b000110, 4'd4);
        cyc("undef_fetch", ex_fetch(1));
        cyc("undef_decode", ex_decode());

        // ORRS immediate to r15: N,Z load, C,V keep their values
        instr(4'hE, 2'b00, 6'b111101, 4'd15);
        ALUFlags = 4'b1010;
        cyc("orrs_fetch", ex_fetch(1));
        cyc("orrs_decode", ex_decode());
        cyc("orrs_exec", ex_exec(1, 3'b101));
        mflags = 4'b1000;
        cyc("orrs_aluwb", ex_aluwb(0, 1));

        // Flags 1000: GT fails, LT passes
        ALUFlags = 4'b0000;
        instr(4'hC, 2'b00, 6'b000000, 4'd5);
        cyc("gt_fetch", ex_fetch(1));
        cyc("gt_decode", ex_decode());
        instr(4'hB, 2'b00, 6'b000000, 4'd5);
        cyc("lt_fetch", ex_fetch(1));
        cyc("lt_decode", ex_decode());
        cyc("lt_exec", ex_exec(0, 3'b000));
        cyc("lt_aluwb", ex_aluwb(0, 0));
        cyc("final_fetch", ex_fetch(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
